// File: rtl/i2s_dac_feeder.sv
// Per-frame I2S DAC feeder: fetches one sample from each of two sources, mixes
// with attenuation and saturation, and writes one word to the DAC FIFO per frame.
module i2s_dac_feeder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FETCH_TIMEOUT = 8
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic                  daclrc,
    input  logic                  enable,
    input  logic                  mute,
    input  logic                  src0_valid,
    input  logic                  src1_valid,
    input  logic [DATA_WIDTH-1:0] src0_data,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src0_ready,
    output logic                  src1_ready,
    input  logic [1:0]            src0_shift,
    input  logic [1:0]            src1_shift,
    input  logic                  fifo_full,
    output logic                  fifo_wren,
    output logic [DATA_WIDTH-1:0] fifo_wrdata,
    output logic [15:0]           underrun_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned CH_W  = DATA_WIDTH / 2;
    localparam int unsigned CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_MIX,
        S_WRITE
    } state_t;

    state_t                r_state, w_state;
    logic                  r_lrc_s1, r_lrc_s2, r_lrc_hist;
    logic                  w_tick;
    logic                  r_got0, r_got1, w_got0, w_got1;
    logic                  r_rdy0, r_rdy1, w_rdy0, w_rdy1;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0] r_s0, r_s1, w_s0, w_s1;
    logic [DATA_WIDTH-1:0] r_mixed, w_mixed;
    logic [DATA_WIDTH-1:0] r_last, w_last;
    logic                  r_wren, w_wren;
    logic [DATA_WIDTH-1:0] r_wrdata, w_wrdata;
    logic [15:0]           r_under, w_under;
    logic [15:0]           r_drop, w_drop;

    // One channel: attenuate both inputs, add with one guard bit, clamp on overflow
    function automatic logic [CH_W-1:0] f_mix_ch(
        input logic [CH_W-1:0] a,
        input logic [CH_W-1:0] b,
        input logic [1:0]      sha,
        input logic [1:0]      shb,
        input logic            ga,
        input logic            gb
    );
        logic signed [CH_W-1:0] a_sh, b_sh;
        logic signed [CH_W:0]   ea, eb, sum;
        a_sh = $signed(a) >>> sha;
        b_sh = $signed(b) >>> shb;
        ea   = ga ? {a_sh[CH_W-1], a_sh} : '0;
        eb   = gb ? {b_sh[CH_W-1], b_sh} : '0;
        sum  = ea + eb;
        if (sum[CH_W] != sum[CH_W-1])
            f_mix_ch = sum[CH_W] ? {1'b1, {(CH_W-1){1'b0}}} : {1'b0, {(CH_W-1){1'b1}}};
        else
            f_mix_ch = sum[CH_W-1:0];
    endfunction

    assign w_tick = r_lrc_hist & ~r_lrc_s2;

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lrc_s1   <= 1'b0;
            r_lrc_s2   <= 1'b0;
            r_lrc_hist <= 1'b0;
            r_got0     <= 1'b0;
            r_got1     <= 1'b0;
            r_rdy0     <= 1'b0;
            r_rdy1     <= 1'b0;
            r_cnt      <= '0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_mixed    <= '0;
            r_last     <= '0;
            r_wren     <= 1'b0;
            r_wrdata   <= '0;
            r_under    <= '0;
            r_drop     <= '0;
        end else begin
            r_state    <= w_state;
            r_lrc_s1   <= daclrc;
            r_lrc_s2   <= r_lrc_s1;
            r_lrc_hist <= r_lrc_s2;
            r_got0     <= w_got0;
            r_got1     <= w_got1;
            r_rdy0     <= w_rdy0;
            r_rdy1     <= w_rdy1;
            r_cnt      <= w_cnt;
            r_s0       <= w_s0;
            r_s1       <= w_s1;
            r_mixed    <= w_mixed;
            r_last     <= w_last;
            r_wren     <= w_wren;
            r_wrdata   <= w_wrdata;
            r_under    <= w_under;
            r_drop     <= w_drop;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        w_state  = r_state;
        w_got0   = r_got0;
        w_got1   = r_got1;
        w_rdy0   = r_rdy0;
        w_rdy1   = r_rdy1;
        w_cnt    = r_cnt;
        w_s0     = r_s0;
        w_s1     = r_s1;
        w_mixed  = r_mixed;
        w_last   = r_last;
        w_wren   = 1'b0;
        w_wrdata = r_wrdata;
        w_under  = r_under;
        w_drop   = r_drop;

        unique case (r_state)
            S_IDLE: begin
                if (w_tick && enable) begin
                    w_state = S_FETCH;
                    w_got0  = 1'b0;
                    w_got1  = 1'b0;
                    w_rdy0  = 1'b1;
                    w_rdy1  = 1'b1;
                    w_cnt   = CNT_W'(FETCH_TIMEOUT - 1);
                end
            end
            S_FETCH: begin
                if (src0_valid && r_rdy0) begin
                    w_s0   = src0_data;
                    w_got0 = 1'b1;
                    w_rdy0 = 1'b0;
                end
                if (src1_valid && r_rdy1) begin
                    w_s1   = src1_data;
                    w_got1 = 1'b1;
                    w_rdy1 = 1'b0;
                end
                if ((w_got0 && w_got1) || (r_cnt == '0)) begin
                    w_state = S_MIX;
                    w_rdy0  = 1'b0;
                    w_rdy1  = 1'b0;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_MIX: begin
                w_state = S_WRITE;
                if (!r_got0 && !r_got1) begin
                    w_mixed = r_last;
                    if (r_under != 16'hFFFF)
                        w_under = r_under + 16'd1;
                end else begin
                    w_mixed = {f_mix_ch(r_s0[DATA_WIDTH-1:CH_W], r_s1[DATA_WIDTH-1:CH_W],
                                        src0_shift, src1_shift, r_got0, r_got1),
                               f_mix_ch(r_s0[CH_W-1:0], r_s1[CH_W-1:0],
                                        src0_shift, src1_shift, r_got0, r_got1)};
                end
            end
            S_WRITE: begin
                if (!fifo_full) begin
                    w_wren   = 1'b1;
                    w_wrdata = mute ? '0 : r_mixed;
                    w_last   = r_mixed;
                    w_state  = S_IDLE;
                end else if (w_tick) begin
                    // Blocked past the next frame: discard and start fetching afresh
                    if (r_drop != 16'hFFFF)
                        w_drop = r_drop + 16'd1;
                    w_state = S_FETCH;
                    w_got0  = 1'b0;
                    w_got1  = 1'b0;
                    w_rdy0  = 1'b1;
                    w_rdy1  = 1'b1;
                    w_cnt   = CNT_W'(FETCH_TIMEOUT - 1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign src0_ready   = r_rdy0;
    assign src1_ready   = r_rdy1;
    assign fifo_wren    = r_wren;
    assign fifo_wrdata  = r_wrdata;
    assign underrun_cnt = r_under;
    assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_i2s_dac_feeder.sv
// Bench for i2s_dac_feeder: table of per-frame vectors with a write scoreboard,
// plus hand sequences for latency, FIFO backpressure, enable and reset.
module tb_i2s_dac_feeder;

    logic        bclk = 1'b0;
    logic        reset_n;
    logic        daclrc;
    logic        enable;
    logic        mute;
    logic        src0_valid, src1_valid;
    logic [31:0] src0_data, src1_data;
    logic        src0_ready, src1_ready;
    logic [1:0]  src0_shift, src1_shift;
    logic        fifo_full;
    logic        fifo_wren;
    logic [31:0] fifo_wrdata;
    logic [15:0] underrun_cnt, drop_cnt;

    i2s_dac_feeder #(.DATA_WIDTH(32), .FETCH_TIMEOUT(8)) dut (
        .bclk        (bclk),
        .reset_n     (reset_n),
        .daclrc      (daclrc),
        .enable      (enable),
        .mute        (mute),
        .src0_valid  (src0_valid),
        .src1_valid  (src1_valid),
        .src0_data   (src0_data),
        .src1_data   (src1_data),
        .src0_ready  (src0_ready),
        .src1_ready  (src1_ready),
        .src0_shift  (src0_shift),
        .src1_shift  (src1_shift),
        .fifo_full   (fifo_full),
        .fifo_wren   (fifo_wren),
        .fifo_wrdata (fifo_wrdata),
        .underrun_cnt(underrun_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 bclk = ~bclk;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic [1:0]  sh0;
        logic [1:0]  sh1;
        logic        mute;
        logic [31:0] exp_word;
        logic [15:0] exp_under;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_writes = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every FIFO write must match the oldest expected word
    always @(negedge bclk) begin
        if (reset_n && fifo_wren) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %h expected no write", fifo_wrdata);
            end else begin
                check32("write_data", fifo_wrdata, exp_q.pop_front());
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge bclk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: got %0d pending writes expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic frame(input string name);
        @(negedge bclk) daclrc = 1'b0;
        wait_drain(name);
        daclrc = 1'b1;
        repeat (4) @(negedge bclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0, lat, rdy;
        vecs[0] = '{1'b1, 32'h1000_2000, 1'b1, 32'h0100_0200, 2'd0, 2'd0, 1'b0, 32'h1100_2200, 16'd0};
        vecs[1] = '{1'b1, 32'h7000_8000, 1'b1, 32'h2000_F000, 2'd0, 2'd0, 1'b0, 32'h7FFF_8000, 16'd0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0400_0400, 2'd0, 2'd2, 1'b0, 32'h0100_0100, 16'd0};
        vecs[3] = '{1'b1, 32'h1234_5678, 1'b1, 32'h0,         2'd0, 2'd0, 1'b0, 32'h1234_5678, 16'd0};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 32'h0,         2'd0, 2'd0, 1'b0, 32'h1234_5678, 16'd1};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 32'h0,         2'd0, 2'd0, 1'b1, 32'h0000_0000, 16'd2};
        vecs[6] = '{1'b1, 32'hFFF0_0040, 1'b1, 32'h0010_FFFF, 2'd3, 2'd1, 1'b0, 32'h0006_0007, 16'd2};
        vecs[7] = '{1'b1, 32'h1000_2000, 1'b1, 32'h0,         2'd0, 2'd0, 1'b1, 32'h0000_0000, 16'd2};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 32'h0,         2'd0, 2'd0, 1'b0, 32'h1000_2000, 16'd3};

        reset_n = 1'b0; daclrc = 1'b1; enable = 1'b1; mute = 1'b0; fifo_full = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0; src0_data = '0; src1_data = '0;
        src0_shift = '0; src1_shift = '0;
        repeat (3) @(negedge bclk);
        check32("rst_wren", 32'(fifo_wren), 32'd0);
        check32("rst_wrdata", fifo_wrdata, 32'd0);
        check32("rst_underrun", 32'(underrun_cnt), 32'd0);
        check32("rst_drop", 32'(drop_cnt), 32'd0);
        check32("rst_ready", 32'({src0_ready, src1_ready}), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge bclk);

        for (int i = 0; i < 9; i++) begin
            src0_valid = vecs[i].v0;  src0_data = vecs[i].d0;
            src1_valid = vecs[i].v1;  src1_data = vecs[i].d1;
            src0_shift = vecs[i].sh0; src1_shift = vecs[i].sh1;
            mute       = vecs[i].mute;
            exp_q.push_back(vecs[i].exp_word);
            frame("vec_write");
            check32("vec_underrun", 32'(underrun_cnt), 32'(vecs[i].exp_under));
            check32("vec_drop", 32'(drop_cnt), 32'd0);
        end

        // Latency: tick is sampled on the 3rd edge after the daclrc fall,
        // the write then follows FETCH_TIMEOUT+2 edges later
        src0_valid = 1'b0; src1_valid = 1'b1; src1_data = 32'h0400_0400;
        src0_shift = 2'd0; src1_shift = 2'd2; mute = 1'b0;
        exp_q.push_back(32'h0100_0100);
        @(negedge bclk) daclrc = 1'b0;
        lat = 0; rdy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge bclk);
            if (src0_ready) rdy++;
            if (fifo_wren && lat == 0) lat = k;
        end
        daclrc = 1'b1;
        repeat (4) @(negedge bclk);
        check32("timeout_latency", 32'(lat), 32'd13);
        check32("src0_ready_cycles", 32'(rdy), 32'd8);
        check32("timeout_pending", 32'(exp_q.size()), 32'd0);

        // Backpressure across two frames: first word dropped, second written once
        fifo_full = 1'b1; src0_valid = 1'b1; src1_valid = 1'b1;
        src0_data = 32'h0001_0001; src1_data = 32'h0; src1_shift = 2'd0;
        w0 = n_writes;
        @(negedge bclk) daclrc = 1'b0;
        repeat (20) @(negedge bclk);
        daclrc = 1'b1;
        repeat (4) @(negedge bclk);
        src0_data = 32'h0002_0003; src1_data = 32'h0010_0020;
        daclrc = 1'b0;
        repeat (20) @(negedge bclk);
        check32("full_drop_cnt", 32'(drop_cnt), 32'd1);
        check32("full_no_write", 32'(n_writes - w0), 32'd0);
        exp_q.push_back(32'h0012_0023);
        fifo_full = 1'b0;
        wait_drain("full_release_write");
        daclrc = 1'b1;
        repeat (10) @(negedge bclk);
        check32("full_single_write", 32'(n_writes - w0), 32'd1);

        // Disabled: a frame edge starts nothing
        enable = 1'b0;
        w0 = n_writes;
        @(negedge bclk) daclrc = 1'b0;
        repeat (20) @(negedge bclk);
        daclrc = 1'b1;
        repeat (4) @(negedge bclk);
        check32("disabled_no_write", 32'(n_writes - w0), 32'd0);
        enable = 1'b1;

        // Reset mid-FETCH
        src0_valid = 1'b0; src1_valid = 1'b0;
        @(negedge bclk) daclrc = 1'b0;
        repeat (6) @(negedge bclk);
        check32("pre_reset_ready", 32'(src0_ready), 32'd1);
        reset_n = 1'b0;
        #1;
        check32("rst_mid_ready", 32'({src0_ready, src1_ready}), 32'd0);
        check32("rst_mid_wren", 32'(fifo_wren), 32'd0);
        check32("rst_mid_wrdata", fifo_wrdata, 32'd0);
        check32("rst_mid_underrun", 32'(underrun_cnt), 32'd0);
        check32("rst_mid_drop", 32'(drop_cnt), 32'd0);
        @(negedge bclk) reset_n = 1'b1;
        w0 = n_writes;
        repeat (20) @(negedge bclk);
        check32("post_reset_no_write", 32'(n_writes - w0), 32'd0);
        check32("post_reset_underrun", 32'(underrun_cnt), 32'd0);
        daclrc = 1'b1;
        repeat (4) @(negedge bclk);
        exp_q.push_back(32'h0);
        frame("post_reset_frame");
        check32("post_reset_frame_underrun", 32'(underrun_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
